alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//  Downstream stage of the reversible-logic arithmetic/logic block.
//  - Takes that block's parallel 32-bit results (xor/not/and/nand/or/nor/a_b_one/Q_peres) plus an opcode and tag.
//  - Selects one result and computes zero/parity/illegal flags.
//  - Registers result and flags into a 2-entry output buffer with valid/ready handshakes on both sides.
//  - Keeps saturating issue and illegal-op counters.
// PARAMETERS
//  WIDTH     32  datapath width of every result bus and out_data
//  TAG_W     4   width of the transaction tag passed through unchanged
//  CNT_W     16  width of the saturating statistics counters
// PORTS
//  clk             in   1      single clock; all state on rising edge
//  rst_n           in   1      reset, asynchronous assert, active-low
//  in_valid        in   1      upstream results/op/tag are valid
//  in_ready        out  1      stage can accept (buffer not full)
//  in_op           in   4      opcode; 0..7 legal, 8..15 illegal
//  in_tag          in   TAG_W  transaction tag
//  xor_result      in   WIDTH  op 0
//  not_result1     in   WIDTH  op 1
//  and_result      in   WIDTH  op 2
//  nand_result     in   WIDTH  op 3
//  or_result       in   WIDTH  op 4
//  nor_result      in   WIDTH  op 5
//  a_b_one_result  in   WIDTH  op 6
//  Q_peres         in   WIDTH  op 7
//  out_valid       out  1      head buffer entry valid
//  out_ready       in   1      downstream accepts head entry
//  out_data        out  WIDTH  selected result (0 for illegal op)
//  out_tag         out  TAG_W  tag of head entry
//  out_zero        out  1      out_data == 0
//  out_parity      out  1      XOR-reduce of out_data
//  out_illegal     out  1      entry carried an illegal opcode
//  issue_cnt       out  CNT_W  accepted transactions, saturating
//  illegal_cnt     out  CNT_W  accepted illegal ops, saturating
// BEHAVIOUR
//  Reset (rst_n low, async): buffer emptied, rd/wr pointers 0, count 0, counters 0.
//   - All out_* read 0 while empty; in_ready = 1 one cycle after deassert.
//  Accept: push when in_valid && in_ready.
//   - Selection and flags computed combinationally, stored in the buffer entry.
//  Pop: when out_valid && out_ready.
//  Latency: accepted item appears on out_valid in the next cycle when the buffer was empty; 1-cycle minimum.
//  in_ready = (count != 2), driven from registered count only.
//   - No combinational path out_ready -> in_ready.
//  Sustained throughput: 1 item/clk while out_ready stays high.
//  Buffer states by count:
//   - EMPTY (0): push -> ONE.
//   - ONE (1): push only -> FULL; pop only -> EMPTY; push+pop -> ONE.
//   - FULL (2): pop -> ONE; no push possible.
//   - Pointers are 1-bit and wrap.
//  Ordering: strict FIFO; tag always travels with its data.
//  Output hold: while out_valid && !out_ready, all out_* hold stable.
//  Illegal op (8..15): entry still accepted and delivered; out_data=0, out_zero=1, out_parity=0, out_illegal=1.
//  Counters: issue_cnt +1 per push; illegal_cnt +1 per illegal push.
//   - Both hold at 2^CNT_W-1 (no wrap).
//  Upstream protocol: in_valid must not drop, and inputs must not change, until accepted. Not checked; the bench asserts it.
//  Mid-operation reset: contents discarded immediately; no partial output after reset.
// STRUCTURE
//  Shared package alu_pkg:
//   - opcode localparams OP_XOR=0 .. OP_PERES_Q=7.
//   - typedef of the entry struct {data, tag, zero, parity, illegal}.
//  Sub-module alu_skid_fifo2:
//   - 2-entry valid/ready FIFO, parameterised on entry width.
//   - Holds count and pointer logic.
//  Top level: opcode mux, flag logic, counters.
// TESTING
//  Reset, then op=0 with xor_result=FFFFFFFF, out_ready=1
//   -> next cycle out_data=FFFFFFFF, zero=0, parity=0, issue_cnt=1.
//  op=2 with and_result=00000000
//   -> out_zero=1, out_parity=0. op=4 with or_result=00000001 -> out_parity=1.
//  out_ready=0, push 3 items back-to-back
//   -> in_ready low after 2 accepted. Release: tags delivered in order, third accepted the cycle after the first pop.
//  op=9, tag=5
//   -> out_illegal=1, out_data=0, out_tag=5, illegal_cnt=1; next legal op unaffected.
//  Random valid/ready, 10k items vs scoreboard
//   -> no loss, no duplication, order kept, outputs stable while stalled.
//  Assert rst_n low with 2 entries buffered
//   -> out_valid=0 immediately, counters 0, no stale item after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcode encodings, buffer states
// and the layout of one buffered result entry.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_TAG_W = 4;

  localparam logic [3:0] OP_XOR     = 4'd0;
  localparam logic [3:0] OP_NOT     = 4'd1;
  localparam logic [3:0] OP_AND     = 4'd2;
  localparam logic [3:0] OP_NAND    = 4'd3;
  localparam logic [3:0] OP_OR      = 4'd4;
  localparam logic [3:0] OP_NOR     = 4'd5;
  localparam logic [3:0] OP_A_B_ONE = 4'd6;
  localparam logic [3:0] OP_PERES_Q = 4'd7;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic [ALU_TAG_W-1:0] tag;
    logic                 zero;
    logic                 parity;
    logic                 illegal;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream results/opcode/tag handshake plus downstream result handshake.
interface alu_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] xor_result;
  logic [WIDTH-1:0] not_result1;
  logic [WIDTH-1:0] and_result;
  logic [WIDTH-1:0] nand_result;
  logic [WIDTH-1:0] or_result;
  logic [WIDTH-1:0] nor_result;
  logic [WIDTH-1:0] a_b_one_result;
  logic [WIDTH-1:0] Q_peres;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_parity;
  logic             out_illegal;

  modport master (
    output in_valid, in_op, in_tag, xor_result, not_result1, and_result,
           nand_result, or_result, nor_result, a_b_one_result, Q_peres,
           out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero, out_parity,
           out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_tag, xor_result, not_result1, and_result,
           nand_result, or_result, nor_result, a_b_one_result, Q_peres,
           out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero, out_parity,
           out_illegal
  );
endinterface

// File: rtl/alu_skid_fifo2.sv
// Two-entry valid/ready FIFO; push_ready is registered so it never depends
// combinationally on pop_ready.
module alu_skid_fifo2
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);
  buf_state_t   state;
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign push      = push_valid && push_ready;
  assign pop       = pop_valid && pop_ready;
  assign pop_valid = (state != BUF_EMPTY);
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

  // push_ready is loaded with "not full" of the state being entered, so it
  // stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BUF_EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      push_ready <= 1'b0;
      mem[0]     <= '0;
      mem[1]     <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case (state)
        BUF_EMPTY: begin
          if (push) state <= BUF_ONE;
          push_ready <= 1'b1;
        end
        BUF_ONE: begin
          if (push && !pop) begin
            state      <= BUF_FULL;
            push_ready <= 1'b0;
          end else begin
            if (pop && !push) state <= BUF_EMPTY;
            push_ready <= 1'b1;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            state      <= BUF_ONE;
            push_ready <= 1'b1;
          end else begin
            push_ready <= 1'b0;
          end
        end
        default: begin
          state      <= BUF_EMPTY;
          push_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Result-select stage: picks one reversible-logic result by opcode, computes
// zero/parity/illegal flags and buffers them with saturating statistics.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = ALU_TAG_W,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_stage_if.slave bus,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);
  localparam int ENTRY_W = WIDTH + TAG_W + 3;

  logic [WIDTH-1:0]   selected;
  logic               illegal;
  logic               push;
  alu_entry_t         in_entry;
  alu_entry_t         out_entry;
  logic [ENTRY_W-1:0] out_vec;

  always_comb begin
    selected = '0;
    case (bus.in_op)
      OP_XOR:     selected = bus.xor_result;
      OP_NOT:     selected = bus.not_result1;
      OP_AND:     selected = bus.and_result;
      OP_NAND:    selected = bus.nand_result;
      OP_OR:      selected = bus.or_result;
      OP_NOR:     selected = bus.nor_result;
      OP_A_B_ONE: selected = bus.a_b_one_result;
      OP_PERES_Q: selected = bus.Q_peres;
      default:    selected = '0;
    endcase
  end

  assign illegal = bus.in_op[3];
  assign push    = bus.in_valid && bus.in_ready;

  always_comb begin
    in_entry.data    = selected;
    in_entry.tag     = bus.in_tag;
    in_entry.zero    = (selected == '0);
    in_entry.parity  = ^selected;
    in_entry.illegal = illegal;
  end

  alu_skid_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (in_entry),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (out_vec)
  );

  // The FIFO zeroes its output while empty, so every out_* field reads 0 then.
  assign out_entry       = out_vec;
  assign bus.out_data    = out_entry.data;
  assign bus.out_tag     = out_entry.tag;
  assign bus.out_zero    = out_entry.zero;
  assign bus.out_parity  = out_entry.parity;
  assign bus.out_illegal = out_entry.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt   <= '0;
      illegal_cnt <= '0;
    end else if (push) begin
      if (issue_cnt != '1) issue_cnt <= issue_cnt + 1'b1;
      if (illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule
